// File: rtl/if_irq_req.sv
// Asynchronous-exception request generator between the timer/interrupt sources and fetch.
// Optional macro EXT_IRQ_SYNC_EN adds a 2-flop synchroniser on ext_irq.
module if_irq_req #(
   parameter int HOLDOFF = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dec_trigger,
   input  logic       ext_irq,
   input  logic       msr_ee,
   input  logic       fetch_inject,
   input  logic       exc_ack,
   input  logic       exc_flush,
   output logic       exc_req,
   output logic [1:0] exc_type,
   output logic       dec_pending
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      FLIGHT = 2'd2
   } state_t;

   localparam logic [1:0] TYPE_NONE = 2'b00;
   localparam logic [1:0] TYPE_EXT  = 2'b01;
   localparam logic [1:0] TYPE_DEC  = 2'b10;

   state_t     state, state_nxt;
   logic [1:0] type_q, type_nxt, cand_type;
   logic [3:0] hold_cnt, hold_cnt_nxt;
   logic       dec_prev, dec_pend, dec_pend_nxt;
   logic       dec_set, dec_clr, load_hold;
   logic       ext_pend, src_live;

`ifdef EXT_IRQ_SYNC_EN
   logic ext_sync1, ext_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         ext_sync1 <= 1'b0;
         ext_sync2 <= 1'b0;
      end else begin
         ext_sync1 <= ext_irq;
         ext_sync2 <= ext_sync1;
      end
   end

   assign ext_pend = ext_sync2;
`else
   assign ext_pend = ext_irq;
`endif

   // Only a low-to-high transition of the decrementer bit creates a new event.
   assign dec_set  = dec_trigger & ~dec_prev;
   assign src_live = (type_q == TYPE_EXT) ? ext_pend : dec_pend;

   always_comb begin
      cand_type = TYPE_NONE;
      if (ext_pend) begin
         cand_type = TYPE_EXT;
      end else if (dec_pend) begin
         cand_type = TYPE_DEC;
      end
   end

   always_comb begin
      state_nxt = state;
      type_nxt  = type_q;
      load_hold = 1'b0;
      dec_clr   = 1'b0;
      case (state)
         IDLE: begin
            type_nxt = TYPE_NONE;
            if ((cand_type != TYPE_NONE) && msr_ee && (hold_cnt == 4'd0)) begin
               state_nxt = REQ;
               type_nxt  = cand_type;
            end
         end
         REQ: begin
            // The latched type never changes here; a higher-priority source waits.
            if (fetch_inject) begin
               state_nxt = FLIGHT;
            end else if (!msr_ee || !src_live) begin
               state_nxt = IDLE;
               type_nxt  = TYPE_NONE;
            end
         end
         FLIGHT: begin
            if (exc_flush) begin
               state_nxt = IDLE;
               type_nxt  = TYPE_NONE;
               load_hold = 1'b1;
            end else if (exc_ack) begin
               state_nxt = IDLE;
               type_nxt  = TYPE_NONE;
               load_hold = 1'b1;
               dec_clr   = (type_q == TYPE_DEC);
            end
         end
         default: begin
            state_nxt = IDLE;
            type_nxt  = TYPE_NONE;
         end
      endcase
   end

   // A fresh edge in the same cycle as the commit must survive, so set beats clear.
   always_comb begin
      dec_pend_nxt = dec_pend;
      if (dec_set) begin
         dec_pend_nxt = 1'b1;
      end else if (dec_clr) begin
         dec_pend_nxt = 1'b0;
      end
   end

   always_comb begin
      hold_cnt_nxt = hold_cnt;
      if (load_hold) begin
         hold_cnt_nxt = 4'(HOLDOFF);
      end else if (hold_cnt != 4'd0) begin
         hold_cnt_nxt = hold_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         type_q   <= TYPE_NONE;
         hold_cnt <= 4'd0;
         dec_prev <= 1'b0;
         dec_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         type_q   <= type_nxt;
         hold_cnt <= hold_cnt_nxt;
         dec_prev <= dec_trigger;
         dec_pend <= dec_pend_nxt;
      end
   end

   assign exc_req     = (state == REQ);
   assign exc_type    = type_q;
   assign dec_pending = dec_pend;

endmodule

// File: tb/tb_if_irq_req.sv
// Self-checking bench for if_irq_req: per-cycle vectors with a scoreboard of expected outputs.
// Works in both the default build and with EXT_IRQ_SYNC_EN defined.
module tb_if_irq_req;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dec_trigger = 1'b0;
   logic       ext_irq = 1'b0;
   logic       msr_ee = 1'b0;
   logic       fetch_inject = 1'b0;
   logic       exc_ack = 1'b0;
   logic       exc_flush = 1'b0;
   logic       exc_req;
   logic [1:0] exc_type;
   logic       dec_pending;

`ifdef EXT_IRQ_SYNC_EN
   localparam int EXT_LAT = 3;
`else
   localparam int EXT_LAT = 1;
`endif

   always #5 clk = ~clk;

   if_irq_req #(.HOLDOFF(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .dec_trigger  (dec_trigger),
      .ext_irq      (ext_irq),
      .msr_ee       (msr_ee),
      .fetch_inject (fetch_inject),
      .exc_ack      (exc_ack),
      .exc_flush    (exc_flush),
      .exc_req      (exc_req),
      .exc_type     (exc_type),
      .dec_pending  (dec_pending)
   );

   typedef struct {
      logic       rst, dt, ei, ee, fi, ack, fl;
      logic       req;
      logic [1:0] typ;
      logic       pend;
      string      name;
   } vec_t;

   typedef struct {
      logic       req;
      logic [1:0] typ;
      logic       pend;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Expected outputs describe the cycle after the one in which the inputs are applied.
   function automatic vec_t mk(string name, logic rst, logic dt, logic ei, logic ee,
                               logic fi, logic ack, logic fl,
                               logic req, logic [1:0] typ, logic pend);
      vec_t v;
      v.name = name; v.rst = rst; v.dt = dt; v.ei = ei; v.ee = ee;
      v.fi = fi; v.ack = ack; v.fl = fl;
      v.req = req; v.typ = typ; v.pend = pend;
      return v;
   endfunction

   task automatic checkOutput();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty: no expected entry for DUT output");
         return;
      end
      e = sb.pop_front();
      if (exc_req !== e.req || exc_type !== e.typ || dec_pending !== e.pend) begin
         errors++;
         $display("[TB] FAIL %s: got req=%b type=%b pend=%b, expected req=%b type=%b pend=%b",
                  e.name, exc_req, exc_type, dec_pending, e.req, e.typ, e.pend);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(negedge clk);
      reset        = v.rst;
      dec_trigger  = v.dt;
      ext_irq      = v.ei;
      msr_ee       = v.ee;
      fetch_inject = v.fi;
      exc_ack      = v.ack;
      exc_flush    = v.fl;
      e.req  = v.req;
      e.typ  = v.typ;
      e.pend = v.pend;
      e.name = v.name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      //           name            rst dt ei ee fi ak fl  req typ    pend
      vecs.push_back(mk("reset0",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("reset1",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("idle_ee",    0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("dec_rise",   0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      vecs.push_back(mk("dec_req",    0, 1, 0, 1, 0, 0, 0, 1, 2'b10, 1));
      vecs.push_back(mk("dec_inject", 0, 1, 0, 1, 1, 0, 0, 0, 2'b10, 1));
      vecs.push_back(mk("flight",     0, 1, 0, 1, 0, 0, 0, 0, 2'b10, 1));
      vecs.push_back(mk("dec_ack",    0, 1, 0, 1, 0, 1, 0, 0, 2'b00, 0));
      vecs.push_back(mk("held_hi0",   0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("held_hi1",   0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("held_hi2",   0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("dec_low",    0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("f_rise",     0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      vecs.push_back(mk("f_req",      0, 1, 0, 1, 0, 0, 0, 1, 2'b10, 1));
      vecs.push_back(mk("f_inject",   0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 1));
      vecs.push_back(mk("ack_flush",  0, 0, 0, 1, 0, 1, 1, 0, 2'b00, 1));
      vecs.push_back(mk("f_hold2",    0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      vecs.push_back(mk("f_hold1",    0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      vecs.push_back(mk("f_reissue",  0, 0, 0, 1, 0, 0, 0, 1, 2'b10, 1));
      vecs.push_back(mk("ee_drop",    0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
      for (int i = 0; i < 20; i++)
         vecs.push_back(mk("ee_masked", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
      vecs.push_back(mk("ee_raise",   0, 0, 0, 1, 0, 0, 0, 1, 2'b10, 1));
      vecs.push_back(mk("c_inject",   0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 1));
      vecs.push_back(mk("collision",  0, 1, 0, 1, 0, 1, 0, 0, 2'b00, 1));
      vecs.push_back(mk("c_hold2",    0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      vecs.push_back(mk("c_hold1",    0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      vecs.push_back(mk("c_reissue",  0, 1, 0, 1, 0, 0, 0, 1, 2'b10, 1));
      vecs.push_back(mk("c_inject2",  0, 1, 0, 1, 1, 0, 0, 0, 2'b10, 1));
      vecs.push_back(mk("c_ack",      0, 1, 0, 1, 0, 1, 0, 0, 2'b00, 0));
      vecs.push_back(mk("c_low",      0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk("idle_stray", 0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 0));

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i]);

      // External and decrementer pending together while masked; unmasking picks external.
      for (int i = 0; i <= EXT_LAT; i++)
         applyStimulus(mk("pri_masked", 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 1));
      applyStimulus(mk("pri_ext",     0, 1, 1, 1, 0, 0, 0, 1, 2'b01, 1));
      applyStimulus(mk("pri_inject",  0, 1, 1, 1, 1, 0, 0, 0, 2'b01, 1));
      applyStimulus(mk("pri_ack",     0, 1, 0, 1, 0, 1, 0, 0, 2'b00, 1));
      applyStimulus(mk("pri_hold2",   0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      applyStimulus(mk("pri_hold1",   0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      applyStimulus(mk("pri_dec_req", 0, 1, 0, 1, 0, 0, 0, 1, 2'b10, 1));
      applyStimulus(mk("pri_dec_inj", 0, 1, 0, 1, 1, 0, 0, 0, 2'b10, 1));
      applyStimulus(mk("pri_dec_ack", 0, 1, 0, 1, 0, 1, 0, 0, 2'b00, 0));
      for (int i = 0; i < 3; i++)
         applyStimulus(mk("pri_settle", 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0));

      // External latency, then withdraw once the level has gone.
      for (int i = 0; i < EXT_LAT; i++) begin
         if (i == EXT_LAT - 1)
            applyStimulus(mk("ext_latency", 0, 1, 1, 1, 0, 0, 0, 1, 2'b01, 0));
         else
            applyStimulus(mk("ext_wait", 0, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0));
      end
      for (int i = 0; i < EXT_LAT; i++) begin
         if (i < EXT_LAT - 1)
            applyStimulus(mk("ext_still", 0, 1, 0, 1, 0, 0, 0, 1, 2'b01, 0));
         else
            applyStimulus(mk("ext_withdraw", 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      end

      // Single-cycle glitch: caught after the input latency, withdrawn a cycle later.
      applyStimulus(mk((EXT_LAT == 1) ? "glitch_caught" : "glitch_pulse",
                       0, 1, 1, 1, 0, 0, 0, (EXT_LAT == 1), (EXT_LAT == 1) ? 2'b01 : 2'b00, 0));
      for (int i = 1; i <= EXT_LAT + 1; i++) begin
         if (i == EXT_LAT - 1)
            applyStimulus(mk("glitch_caught", 0, 1, 0, 1, 0, 0, 0, 1, 2'b01, 0));
         else
            applyStimulus(mk("glitch_quiet", 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      end

      // Reset while an exception is in flight discards it and the pending event.
      applyStimulus(mk("r_low",      0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      applyStimulus(mk("r_rise",     0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 1));
      applyStimulus(mk("r_req",      0, 0, 0, 1, 0, 0, 0, 1, 2'b10, 1));
      applyStimulus(mk("r_inject",   0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 1));
      applyStimulus(mk("r_reset0",   1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      applyStimulus(mk("r_reset1",   1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      applyStimulus(mk("r_after",    0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      applyStimulus(mk("r_after2",   0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 0));

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/if_irq_req.md
# if_irq_req

Exception-request generator between the TB/DEC timer logic and the fetch stage. Latches the decrementer trigger edge as a pending event, qualifies it and the external interrupt line with MSR[EE], and presents one prioritised asynchronous-exception request to IF. It then tracks that request until writeback commits or flushes it, and clears the decrementer pending bit only on commit.

## Interface

Parameters:
- HOLDOFF, default 2: cycles new requests are suppressed after an ack or flush; range 0..15.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- dec_trigger  in  1  registered DEC[31] from timer block; level.
- ext_irq  in  1  external interrupt, level, active-high.
- msr_ee  in  1  current MSR[EE].
- fetch_inject  in  1  IF accepts the request this cycle (valid only with exc_req=1).
- exc_ack  in  1  writeback committed the injected exception entry.
- exc_flush  in  1  pipeline killed the injected exception before commit.
- exc_req  out  1  registered request to IF.
- exc_type  out  2  01 = external (vector 0x500), 10 = decrementer (vector 0x900); 00 when idle.
- dec_pending  out  1  decrementer event pending, for debug/SPR readback.

## Operation

- dec_prev register holds last dec_trigger. dec_pend is set when dec_trigger=1 and dec_prev=0.
- dec_pend is cleared only on exc_ack while the in-flight type is 10. Set and clear in the same cycle: set wins, so the new edge stays pending.
- ext_irq is not latched. Its pending state is its level after the optional synchroniser.
- Candidate type: 01 if ext_irq, else 10 if dec_pend, else none. External has priority.
- Holdoff counter hold_cnt, 4 bits. Loaded with HOLDOFF on exc_ack or exc_flush. Decrements to 0 and saturates.
- States:
  - IDLE. Go to REQ when a candidate exists, msr_ee=1 and hold_cnt=0. exc_type is latched from the candidate.
  - REQ. exc_req=1 and exc_type is held stable.
    - fetch_inject=1: go to FLIGHT.
    - Else msr_ee=0, or the latched source is no longer pending: withdraw to IDLE with exc_req=0.
    - Type is never switched within REQ. A higher-priority source waits for withdraw or completion.
  - FLIGHT. exc_req=0 and exc_type is held.
    - exc_ack: go to IDLE, clear dec_pend if type 10, load holdoff.
    - exc_flush: go to IDLE with no clear, load holdoff.
    - ack and flush together: flush wins.
    - msr_ee and source changes are ignored.
- fetch_inject, exc_ack and exc_flush are ignored in states where they are not meaningful.

## Timing

- Reset values: exc_req=0, exc_type=00, dec_pending=0, state=IDLE, hold_cnt=0, dec_prev=0, synchroniser flops=0.
- Decrementer latency, no synchroniser:
  - dec_trigger rises in cycle n.
  - dec_pending=1 in cycle n+1.
  - exc_req=1 in cycle n+2, provided IDLE, msr_ee=1 and hold_cnt=0 in n+1.
- External latency: ext_irq high in cycle n gives exc_req in n+1. The synchroniser adds 2 cycles.
- Handshake: the request is consumed in the cycle fetch_inject=1 and exc_req=1. exc_req=0 the next cycle.
- After exc_ack or flush in cycle m: hold_cnt=HOLDOFF at m+1, and the earliest new exc_req is at m+HOLDOFF+2. With HOLDOFF=0, the earliest is m+2.
- dec_trigger held high does not re-pend. A new event needs a low-to-high transition.
- Reset mid-FLIGHT abandons the exception. dec_pend is lost.

## Configuration

- EXT_IRQ_SYNC_EN defined: ext_irq passes a 2-flop synchroniser before use, for board-level asynchronous sources. External-to-exc_req latency is 3 cycles.
- Undefined: ext_irq is used directly and must already be synchronous to clk. Latency is 1 cycle.

## Test plan

- Reset, then DEC edge: pulse reset, set msr_ee=1, raise dec_trigger at cycle 10 -> dec_pending=1 at 11, exc_req=1 with exc_type=10 at 12. fetch_inject at 13 -> exc_req=0 at 14. exc_ack at 16 -> dec_pending=0 at 17, and no further request while dec_trigger stays high.
- Priority: dec_pend=1 and ext_irq=1 in the same cycle, IDLE -> exc_type=01. After ack with HOLDOFF=2 and ext_irq low, a type-10 request appears exactly 4 cycles after the ack.
- EE masking: dec_pend=1, msr_ee=0 for 20 cycles -> no exc_req. Raise msr_ee -> exc_req next cycle. Drop msr_ee while in REQ, before inject -> exc_req=0 next cycle and dec_pending stays 1.
- Flush: type-10 request injected, then exc_flush in FLIGHT -> dec_pending stays 1, and the request re-issues after holdoff. ack plus flush in the same cycle is treated as flush.
- Set/clear collision: new dec_trigger rising edge in the same cycle as exc_ack for type 10 -> dec_pending remains 1.
- With EXT_IRQ_SYNC_EN: ext_irq rises at cycle 20 -> exc_req at 23. A 1-cycle glitch is caught at 23 and withdrawn at 24 if not injected.
